uart_cfg_regfile: RTL and testbench

Parametrised UART configuration register file for `fpga_core`. It consumes the byte stream from the UART receiver, decodes framed write and read commands with address, multi-byte payload and XOR checksum, and holds `NUM_REGS` configuration registers of `REG_WIDTH` bits. These replace the fixed gate/loop/aer single-byte decode. Each frame is answered on the UART transmit stream with an ACK/NAK or read-back data, and a timeout discards abandoned frames.

---
 rtl/uart_cfg_pkg.sv | 17 +
 rtl/uart_cfg_timeout.sv | 30 +++
 rtl/uart_cfg_regfile.sv | 169 ++++++++++++++++
 tb/tb_uart_cfg_regfile.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_cfg_pkg.sv
// Shared types and constants for the UART configuration register file.
package uart_cfg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_CSUM = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    localparam logic       OP_WRITE = 1'b0;
    localparam logic       OP_READ  = 1'b1;
    localparam logic [7:0] ACK      = 8'h06;
    localparam logic [7:0] NAK      = 8'h15;
    localparam int         ADDR_W   = 7;

endpackage

// File: rtl/uart_cfg_timeout.sv
// Inter-byte idle timer: down-counter reloaded on clr, held when disabled,
// pulses expired on the terminal count.
module uart_cfg_timeout #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic expired
);

    localparam int            CW      = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] TC_LOAD = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt;

    assign expired = en && !clr && (cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= TC_LOAD;
        end else if (clr || expired) begin
            cnt <= TC_LOAD;
        end else if (en) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/uart_cfg_regfile.sv
// Framed UART command decoder with checksum, holding NUM_REGS config registers
// and answering each frame with ACK/NAK or read-back data.
//
// state | meaning
// IDLE  | waiting for header byte
// DATA  | collecting write payload bytes, LSB first
// CSUM  | waiting for frame checksum byte
// RESP  | sending ACK/NAK or read data + checksum; rx back-pressured
module uart_cfg_regfile
    import uart_cfg_pkg::*;
#(
    parameter int NUM_REGS       = 4,
    parameter int REG_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    rx_tdata,
    input  logic                          rx_tvalid,
    output logic                          rx_tready,
    output logic [7:0]                    tx_tdata,
    output logic                          tx_tvalid,
    input  logic                          tx_tready,
    output logic [NUM_REGS*REG_WIDTH-1:0] cfg_regs,
    output logic [NUM_REGS-1:0]           cfg_wr_stb,
    output logic [7:0]                    err_count
);

    localparam int              NB         = REG_WIDTH / 8;
    localparam logic [2:0]      NB_L       = 3'(NB);
    localparam logic [2:0]      NB_M1      = 3'(NB - 1);
    localparam logic [ADDR_W:0] NUM_REGS_L = (ADDR_W + 1)'(NUM_REGS);

    state_t                state, state_next;
    logic                  hdr_op;
    logic [ADDR_W-1:0]     hdr_addr;
    logic [2:0]            byte_cnt;
    logic [REG_WIDTH-1:0]  data_buf;
    logic [7:0]            csum_acc;
    logic [REG_WIDTH-1:0]  regs [NUM_REGS];
    logic [REG_WIDTH-1:0]  rd_word;
    logic [7:0]            rd_csum;
    logic [REG_WIDTH-1:0]  tx_shift;
    logic [7:0]            tx_csum;
    logic [2:0]            tx_left;
    logic                  rx_hs, tx_hs, csum_hs, frame_ok, err_evt, expired, tmo_en;

    assign rx_tready = !rst && (state != ST_RESP);
    assign rx_hs     = rx_tvalid && rx_tready;
    assign tx_hs     = tx_tvalid && tx_tready;
    assign csum_hs   = (state == ST_CSUM) && rx_hs;
    assign frame_ok  = ({1'b0, hdr_addr} < NUM_REGS_L) && ((csum_acc ^ rx_tdata) == 8'h00);
    assign err_evt   = (csum_hs && !frame_ok) || expired;
    assign tmo_en    = (state == ST_DATA) || (state == ST_CSUM);

    uart_cfg_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .en      (tmo_en),
        .clr     (rx_hs),
        .expired (expired)
    );

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign cfg_regs[g*REG_WIDTH +: REG_WIDTH] = regs[g];
    end

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (hdr_addr == ADDR_W'(i)) rd_word = regs[i];
        end
        rd_csum = 8'h00;
        for (int i = 0; i < NB; i++) rd_csum = rd_csum ^ rd_word[i*8 +: 8];
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (rx_hs) state_next = rx_tdata[7] ? ST_CSUM : ST_DATA;
            ST_DATA: begin
                if (expired) state_next = ST_IDLE;
                else if (rx_hs && byte_cnt == NB_M1) state_next = ST_CSUM;
            end
            ST_CSUM: begin
                if (expired) state_next = ST_IDLE;
                else if (rx_hs) state_next = ST_RESP;
            end
            ST_RESP: if (tx_hs && tx_left == 3'd0) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hdr_op     <= OP_WRITE;
            hdr_addr   <= '0;
            byte_cnt   <= '0;
            data_buf   <= '0;
            csum_acc   <= '0;
            tx_shift   <= '0;
            tx_csum    <= '0;
            tx_left    <= '0;
            tx_tdata   <= '0;
            tx_tvalid  <= 1'b0;
            cfg_wr_stb <= '0;
            err_count  <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            cfg_wr_stb <= '0;
            if (rx_hs) begin
                case (state)
                    ST_IDLE: begin
                        hdr_op   <= rx_tdata[7];
                        hdr_addr <= rx_tdata[ADDR_W-1:0];
                        csum_acc <= rx_tdata;
                        byte_cnt <= '0;
                    end
                    ST_DATA: begin
                        data_buf <= (data_buf >> 8) | (REG_WIDTH'(rx_tdata) << (REG_WIDTH - 8));
                        csum_acc <= csum_acc ^ rx_tdata;
                        byte_cnt <= byte_cnt + 1'b1;
                    end
                    default: ;
                endcase
            end
            if (csum_hs) begin
                tx_tvalid <= 1'b1;
                tx_left   <= '0;
                if (!frame_ok) begin
                    tx_tdata <= NAK;
                end else if (hdr_op == OP_WRITE) begin
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (hdr_addr == ADDR_W'(i)) begin
                            regs[i]       <= data_buf;
                            cfg_wr_stb[i] <= 1'b1;
                        end
                    end
                    tx_tdata <= ACK;
                end else begin
                    tx_tdata <= rd_word[7:0];
                    tx_shift <= rd_word >> 8;
                    tx_csum  <= rd_csum;
                    tx_left  <= NB_L;
                end
            end else if (tx_hs) begin
                if (tx_left == 3'd0) begin
                    tx_tvalid <= 1'b0;
                end else begin
                    // Last step of a read response sends the folded checksum.
                    if (tx_left == 3'd1) begin
                        tx_tdata <= tx_csum;
                    end else begin
                        tx_tdata <= tx_shift[7:0];
                        tx_shift <= tx_shift >> 8;
                    end
                    tx_left <= tx_left - 1'b1;
                end
            end
            if (err_evt && err_count != 8'hFF) err_count <= err_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_cfg_regfile.sv
// Scoreboard bench for uart_cfg_regfile: expected tx bytes are queued when a
// frame is driven and popped as the DUT transmits them.
module tb_uart_cfg_regfile;

    localparam int NR = 4;
    localparam int RW = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic [7:0]     rx_tdata;
    logic           rx_tvalid;
    logic           rx_tready;
    logic [7:0]     tx_tdata;
    logic           tx_tvalid;
    logic           tx_tready;
    logic [NR*RW-1:0] cfg_regs;
    logic [NR-1:0]  cfg_wr_stb;
    logic [7:0]     err_count;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0]  exp_q[$];
    logic [15:0] mdl [4];
    int          err_m;
    int          stb_cnt = 0;
    int          stb_exp = 0;

    uart_cfg_regfile #(.NUM_REGS(NR), .REG_WIDTH(RW), .TIMEOUT_CYCLES(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_tdata   (rx_tdata),
        .rx_tvalid  (rx_tvalid),
        .rx_tready  (rx_tready),
        .tx_tdata   (tx_tdata),
        .tx_tvalid  (tx_tvalid),
        .tx_tready  (tx_tready),
        .cfg_regs   (cfg_regs),
        .cfg_wr_stb (cfg_wr_stb),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mdl_flat();
        return {mdl[3], mdl[2], mdl[1], mdl[0]};
    endfunction

    always @(negedge clk) begin
        if (!rst && tx_tvalid && tx_tready) begin
            if (exp_q.size() == 0) check("tx_unexpected", {56'd0, tx_tdata}, 64'hFFFF);
            else check("tx_byte", {56'd0, tx_tdata}, {56'd0, exp_q.pop_front()});
        end
        if (|cfg_wr_stb) stb_cnt++;
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_tdata  = b;
        rx_tvalid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!rx_tready && n < 200);
        if (n >= 200) check("rx_ready_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        rx_tvalid = 1'b0;
    endtask

    // Pushes the model's expected response, drives the frame, checks the strobe.
    task automatic send_frame(input int n, input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3);
        logic [7:0] fr [4];
        logic [7:0] cs = 8'h00;
        logic [6:0] a;
        logic [3:0] stb_e = 4'b0000;
        logic [15:0] w;
        logic ok;
        fr[0] = b0; fr[1] = b1; fr[2] = b2; fr[3] = b3;
        a = b0[6:0];
        for (int i = 0; i < n - 1; i++) cs = cs ^ fr[i];
        ok = (cs == fr[n-1]) && (a < 7'd4);
        if (!ok) begin
            exp_q.push_back(8'h15);
            if (err_m < 255) err_m++;
        end else if (!b0[7]) begin
            mdl[a[1:0]] = {b2, b1};
            stb_e[a[1:0]] = 1'b1;
            stb_exp++;
            exp_q.push_back(8'h06);
        end else begin
            w = mdl[a[1:0]];
            exp_q.push_back(w[7:0]);
            exp_q.push_back(w[15:8]);
            exp_q.push_back(w[7:0] ^ w[15:8]);
        end
        for (int i = 0; i < n; i++) send_byte(fr[i]);
        @(negedge clk);
        check("wr_stb", {60'd0, cfg_wr_stb}, {60'd0, stb_e});
    endtask

    task automatic finish_frame();
        int n = 0;
        while (!(exp_q.size() == 0 && !tx_tvalid && rx_tready) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("resp_timeout", 64'd0, 64'd1);
        check("regs", cfg_regs, mdl_flat());
        check("err_count", {56'd0, err_count}, 64'(err_m));
        check("stb_pulses", 64'(stb_cnt), 64'(stb_exp));
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; rx_tvalid = 1'b0; rx_tdata = 8'h00; tx_tready = 1'b1;
        err_m = 0;
        for (int i = 0; i < 4; i++) mdl[i] = 16'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_outs", {cfg_regs[15:0], 4'(cfg_wr_stb), err_count, tx_tdata, 2'(tx_tvalid), 2'(rx_tready)},
              {16'h0, 4'h0, 8'h00, 8'h00, 2'd0, 2'd0});
        check("rst_regs", cfg_regs, 64'd0);
        @(posedge clk); #1; rst = 1'b0;

        // Write reg1 = 0xBEEF
        send_frame(4, 8'h01, 8'hEF, 8'hBE, 8'h50);
        finish_frame();
        check("reg1_beef", {48'd0, cfg_regs[31:16]}, 64'hBEEF);
        check("others_zero", {cfg_regs[63:32], cfg_regs[15:0]}, 48'd0);

        // Read reg1, back-to-back response
        send_frame(2, 8'h81, 8'h81, 8'h00, 8'h00);
        finish_frame();

        // Bad checksum, then bad address
        send_frame(4, 8'h02, 8'h34, 8'h12, 8'h00);
        finish_frame();
        check("bad_csum_err", {56'd0, err_count}, 64'd1);
        send_frame(4, 8'h05, 8'h11, 8'h22, 8'h36);
        finish_frame();
        check("bad_addr_err", {56'd0, err_count}, 64'd2);

        // Timeout: counts on the 64th idle cycle, not the 63rd
        send_byte(8'h00);
        send_byte(8'h11);
        repeat (63) @(posedge clk);
        @(negedge clk);
        check("tmo_early", {56'd0, err_count}, 64'd2);
        @(posedge clk);
        @(negedge clk);
        err_m++;
        check("tmo_err", {56'd0, err_count}, 64'd3);
        check("tmo_no_tx", {63'd0, tx_tvalid}, 64'd0);
        @(posedge clk); #1;
        send_frame(4, 8'h00, 8'h34, 8'h12, 8'h26);
        finish_frame();
        check("reg0_after_tmo", {48'd0, cfg_regs[15:0]}, 64'h1234);

        // Back-pressure during a read response
        tx_tready = 1'b0;
        send_frame(2, 8'h81, 8'h81, 8'h00, 8'h00);
        for (int i = 0; i < 20; i++) begin
            rx_tvalid = 1'b1;
            rx_tdata  = 8'h55;
            @(negedge clk);
            check("bp_hold", {54'd0, tx_tvalid, rx_tready, tx_tdata}, {54'd0, 1'b1, 1'b0, 8'hEF});
        end
        rx_tvalid = 1'b0;
        tx_tready = 1'b1;
        finish_frame();

        // Saturation: 256 out-of-range reads
        for (int i = 0; i < 256; i++) begin
            send_frame(2, 8'hFF, 8'hFF, 8'h00, 8'h00);
            finish_frame();
        end
        check("err_sat", {56'd0, err_count}, 64'hFF);

        // Reset mid-frame
        send_byte(8'h03);
        send_byte(8'hAA);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid", {cfg_regs, 4'(cfg_wr_stb), err_count, tx_tdata, 2'(tx_tvalid), 2'(rx_tready)},
              {64'd0, 4'h0, 8'h00, 8'h00, 2'd0, 2'd0});
        @(posedge clk); #1; rst = 1'b0;
        for (int i = 0; i < 4; i++) mdl[i] = 16'h0;
        err_m = 0;
        exp_q.delete();
        send_frame(4, 8'h03, 8'h78, 8'h56, 8'h2D);
        finish_frame();
        check("reg3_after_rst", {48'd0, cfg_regs[63:48]}, 64'h5678);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
